mac_div: RTL

- Inverse of the MAC datapath. Given a MAC result P, the addend C and the multiplier B, it recovers A = (P - C) / B and the remainder.
- Sequential restoring divider, one quotient bit per clock.
- Valid/ready handshake on both input and output.
- Used to check MAC results in-system and to de-scale accumulated values.

---
 rtl/mac_div.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mac_div.sv
// mac_div: recovers A = (P - C) / B and the remainder from a MAC result.
// Restoring divider that produces one quotient bit per clock, MSB first.
// Valid/ready handshake on the operand side and on the result side.
// Optional feature macro: MAC_DIV_STATS_EN adds op_count / err_count outputs.
module mac_div #(
  parameter  int WIDTH_A = 5,
  parameter  int WIDTH_B = 7,
  localparam int N       = WIDTH_A + WIDTH_B
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       P,
  input  logic [N-1:0]       C,
  input  logic [WIDTH_B-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       quot,
  output logic [WIDTH_B-1:0] rem,
  output logic               err_div0,
  output logic               err_under
`ifdef MAC_DIV_STATS_EN
  ,
  output logic [15:0]        op_count,
  output logic [7:0]         err_count
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [N:0]         diff_q, diff_d;
  logic [WIDTH_B-1:0] div_q, div_d;
  logic [WIDTH_B-1:0] part_q, part_d;
  logic [N-1:0]       shift_q, shift_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N-1:0]       quot_q, quot_d;
  logic [WIDTH_B-1:0] rem_q, rem_d;
  logic               div0_q, div0_d;
  logic               under_q, under_d;

  logic [WIDTH_B:0]   trial;
  logic [WIDTH_B-1:0] subRem;
  logic               fits;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign err_div0  = div0_q;
  assign err_under = under_q;

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      diff_q  <= '0;
      div_q   <= '0;
      part_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      diff_q  <= diff_d;
      div_q   <= div_d;
      part_q  <= part_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      under_q <= under_d;
    end
  end

  // Next-state logic; the dividend register doubles as the quotient register
  always_comb begin
    state_d = state_q;
    diff_d  = diff_q;
    div_d   = div_q;
    part_d  = part_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    under_d = under_q;

    trial  = {part_q, shift_q[N-1]};
    fits   = (trial >= {1'b0, div_q});
    subRem = WIDTH_B'(trial - {1'b0, div_q});

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d   = B;
          diff_d  = {1'b0, P} - {1'b0, C};
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (div_q == '0) begin
          div0_d  = 1'b1;
          quot_d  = '0;
          rem_d   = '0;
          state_d = DONE;
        end else if (diff_q[N]) begin
          under_d = 1'b1;
          quot_d  = '0;
          rem_d   = '0;
          state_d = DONE;
        end else begin
          part_d  = '0;
          shift_d = diff_q[N-1:0];
          cnt_d   = CW'(N - 1);
          state_d = DIV;
        end
      end
      DIV: begin
        part_d  = fits ? subRem : trial[WIDTH_B-1:0];
        shift_d = {shift_q[N-2:0], fits};
        if (cnt_q == '0) begin
          quot_d  = shift_d;
          rem_d   = part_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          div0_d  = 1'b0;
          under_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MAC_DIV_STATS_EN
  logic [15:0] opCount_q;
  logic [7:0]  errCount_q;

  assign op_count  = opCount_q;
  assign err_count = errCount_q;

  // Result-handshake counters: total wraps, error count saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      opCount_q  <= '0;
      errCount_q <= '0;
    end else if (out_valid && out_ready) begin
      opCount_q <= opCount_q + 16'd1;
      if ((div0_q || under_q) && (errCount_q != 8'hFF)) begin
        errCount_q <= errCount_q + 8'd1;
      end
    end
  end
`endif

endmodule
